// File: rtl/exec_unit_md_pkg.sv
// Shared encodings for the execute stage: ALU/MD opcodes, operand selects,
// forwarding selects and the multiply/divide sequencing states.
package exec_unit_md_pkg;

  typedef enum logic [5:0] {
    ALU_ADD    = 6'h00,
    ALU_SUB    = 6'h01,
    ALU_SLL    = 6'h02,
    ALU_SLT    = 6'h03,
    ALU_SLTU   = 6'h04,
    ALU_XOR    = 6'h05,
    ALU_SRL    = 6'h06,
    ALU_SRA    = 6'h07,
    ALU_OR     = 6'h08,
    ALU_AND    = 6'h09,
    ALU_PASSB  = 6'h0A,
    ALU_STORE  = 6'h0B,
    MD_MUL     = 6'h20,
    MD_MULH    = 6'h21,
    MD_MULHSU  = 6'h22,
    MD_MULHU   = 6'h23,
    MD_DIV     = 6'h24,
    MD_DIVU    = 6'h25,
    MD_REM     = 6'h26,
    MD_REMU    = 6'h27
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_WB    = 2'b01,
    FWD_MEM   = 2'b10,
    FWD_NONE3 = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    OPA_RS1  = 2'b00,
    OPA_PC   = 2'b01,
    OPA_PC4  = 2'b10,
    OPA_ZERO = 2'b11
  } op_a_sel_e;

  localparam logic OPB_REG = 1'b0;
  localparam logic OPB_IMM = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } state_e;

  // MD opcodes occupy 0x20..0x27; bit 2 separates divide from multiply.
  function automatic logic is_md_op(input logic [5:0] c);
    return c[5:3] == 3'b100;
  endfunction

endpackage

// File: rtl/exec_unit_md_if.sv
// Decode-to-execute and execute-to-memory bundle for exec_unit_md.
interface exec_unit_md_if #(parameter int XLEN = 32);
  logic            in_valid, in_ready;
  logic [1:0]      op_a_sel;
  logic            op_b_sel;
  logic [5:0]      alu_ctrl;
  logic [XLEN-1:0] rdata1, rdata2, imm, pc;
  logic [1:0]      fwd_sel_a, fwd_sel_b;
  logic [XLEN-1:0] wb_data, mem_alu, mem_load_data;
  logic            mem_is_load;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_result, out_store_data;
  logic            md_busy;

  modport master (
    output in_valid, op_a_sel, op_b_sel, alu_ctrl, rdata1, rdata2, imm, pc,
           fwd_sel_a, fwd_sel_b, wb_data, mem_alu, mem_load_data, mem_is_load,
           out_ready,
    input  in_ready, out_valid, out_result, out_store_data, md_busy
  );

  modport slave (
    input  in_valid, op_a_sel, op_b_sel, alu_ctrl, rdata1, rdata2, imm, pc,
           fwd_sel_a, fwd_sel_b, wb_data, mem_alu, mem_load_data, mem_is_load,
           out_ready,
    output in_ready, out_valid, out_result, out_store_data, md_busy
  );
endinterface

// File: rtl/exec_unit_md_muldiv.sv
// Iterative shift-add multiplier / restoring divider (muldiv_iter), one bit per
// cycle on magnitudes with a final sign-fix cycle. Present only with EXEC_MULDIV_EN.
`ifdef EXEC_MULDIV_EN
module muldiv_iter
  import exec_unit_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN + 1);

  logic [2*XLEN-1:0] p, p_nxt, prod;
  logic [XLEN-1:0]   mag, a_raw, ma, mb, q, r, res_nxt;
  logic [5:0]        op_q;
  logic              neg_lo, neg_r, b_zero, run, fix;
  logic [CW-1:0]     step;
  logic              sa, sb, a_neg, b_neg, is_div;
  logic [XLEN:0]     sum, tr, diff;

  always_comb begin
    sa     = (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
             (op == MD_DIV) || (op == MD_REM);
    sb     = (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    a_neg  = sa && a[XLEN-1];
    b_neg  = sb && b[XLEN-1];
    ma     = a_neg ? -a : a;
    mb     = b_neg ? -b : b;
    is_div = op[2];
  end

  // p holds {acc, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    sum  = {1'b0, p[2*XLEN-1:XLEN]} + {1'b0, mag & {XLEN{p[0]}}};
    tr   = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    diff = tr - {1'b0, mag};
    if (op_q[2])
      p_nxt = diff[XLEN] ? {tr[XLEN-1:0], p[XLEN-2:0], 1'b0}
                         : {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
    else
      p_nxt = {sum, p[XLEN-1:1]};
  end

  always_comb begin
    prod = neg_lo ? -p : p;
    q    = neg_lo ? -p[XLEN-1:0] : p[XLEN-1:0];
    r    = neg_r ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
    if (b_zero) begin
      q = '1;
      r = a_raw;
    end
    res_nxt = '0;
    case (op_q)
      MD_MUL:                       res_nxt = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res_nxt = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              res_nxt = q;
      MD_REM, MD_REMU:              res_nxt = r;
      default:                      res_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0; mag <= '0; a_raw <= '0; op_q <= '0;
      neg_lo <= 1'b0; neg_r <= 1'b0; b_zero <= 1'b0;
      run <= 1'b0; fix <= 1'b0; step <= '0;
      done <= 1'b0; result <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        p      <= {{XLEN{1'b0}}, is_div ? ma : mb};
        mag    <= is_div ? mb : ma;
        a_raw  <= a;
        op_q   <= op;
        neg_lo <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        b_zero <= (b == '0);
        run    <= 1'b1;
        fix    <= 1'b0;
        step   <= '0;
      end else if (run) begin
        p    <= p_nxt;
        step <= step + 1'b1;
        if (step == CW'(XLEN-1)) begin
          run <= 1'b0;
          fix <= 1'b1;
        end
      end else if (fix) begin
        fix    <= 1'b0;
        done   <= 1'b1;
        result <= res_nxt;
      end
    end
  end
endmodule
`endif

// File: rtl/exec_unit_md.sv
// Execute stage: operand forwarding, single-cycle ALU and optional iterative
// multiply/divide (macro EXEC_MULDIV_EN) behind a registered valid/ready output.
module exec_unit_md
  import exec_unit_md_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit FWD_EN_B_IMM = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  exec_unit_md_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] mem_fwd, a_src, op_a, op_b, fwd_b, store_d, alu_res, md_res;
  logic [XLEN-1:0] res_q, st_q;
  logic            vld_q, in_ready, xfer, is_md, load_md, md_done;
  state_e          state;

  always_comb begin
    mem_fwd = bus.mem_is_load ? bus.mem_load_data : bus.mem_alu;
    case (bus.op_a_sel)
      OPA_RS1: a_src = bus.rdata1;
      OPA_PC:  a_src = bus.pc;
      OPA_PC4: a_src = bus.pc + XLEN'(4);
      default: a_src = '0;
    endcase
    case (bus.fwd_sel_a)
      FWD_WB:  op_a = bus.wb_data;
      FWD_MEM: op_a = mem_fwd;
      default: op_a = a_src;
    endcase
    case (bus.fwd_sel_b)
      FWD_WB:  fwd_b = bus.wb_data;
      FWD_MEM: fwd_b = mem_fwd;
      default: fwd_b = bus.rdata2;
    endcase
    op_b = (bus.op_b_sel == OPB_IMM) ? bus.imm : fwd_b;
    // Store data normally bypasses forwarding when B is the immediate.
    store_d = '0;
    if (bus.alu_ctrl == ALU_STORE)
      store_d = (bus.op_b_sel == OPB_IMM && !FWD_EN_B_IMM) ? bus.rdata2 : fwd_b;
  end

  always_comb begin
    alu_res = '0;
    case (bus.alu_ctrl)
      ALU_ADD, ALU_STORE: alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_SLL:   alu_res = op_a << op_b[SHW-1:0];
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SRL:   alu_res = op_a >> op_b[SHW-1:0];
      ALU_SRA:   alu_res = $signed(op_a) >>> op_b[SHW-1:0];
      ALU_OR:    alu_res = op_a | op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = '0;
    endcase
  end

  assign in_ready = (state == IDLE) && (!vld_q || bus.out_ready);
  assign xfer     = bus.in_valid && in_ready;

`ifdef EXEC_MULDIV_EN
  state_e         state_nxt;
  logic [SHW-1:0] cnt;

  assign is_md   = is_md_op(bus.alu_ctrl);
  assign load_md = (state == MD_DONE) && md_done;
  assign bus.md_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == MD_RUN) cnt <= (cnt == SHW'(XLEN-1)) ? '0 : cnt + 1'b1;
      else                 cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && is_md)          state_nxt = MD_RUN;
      MD_RUN:  if (cnt == SHW'(XLEN-1))    state_nxt = MD_DONE;
      MD_DONE: if (md_done)                state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  muldiv_iter #(.XLEN(XLEN)) u_md (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (xfer && is_md),
    .op     (bus.alu_ctrl),
    .a      (op_a),
    .b      (op_b),
    .done   (md_done),
    .result (md_res)
  );
`else
  assign state       = IDLE;
  assign is_md       = 1'b0;
  assign load_md     = 1'b0;
  assign md_done     = 1'b0;
  assign md_res      = '0;
  assign bus.md_busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      res_q <= '0;
      st_q  <= '0;
    end else if (xfer && !is_md) begin
      vld_q <= 1'b1;
      res_q <= alu_res;
      st_q  <= store_d;
    end else if (load_md) begin
      vld_q <= 1'b1;
      res_q <= md_res;
      st_q  <= '0;
    end else if (bus.out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = vld_q;
  assign bus.out_result     = res_q;
  assign bus.out_store_data = st_q;
endmodule

// File: tb/tb_exec_unit_md.sv
// Self-checking bench for exec_unit_md: random ops against an ISA-level model,
// directed boundary cases, backpressure and reset behaviour.
module tb_exec_unit_md;
  import exec_unit_md_pkg::*;

  localparam int XLEN = 32;
  localparam bit FWD_EN = 1'b0;

  typedef struct {
    logic [5:0]  ctrl;
    logic [1:0]  asel;
    logic        bsel;
    logic [31:0] r1, r2, imm, pc;
    logic [1:0]  fa, fb;
    logic [31:0] wb, malu, mld;
    logic        mil;
  } op_t;

  logic clk, rst_n;
  int   errors = 0;
  int   checks = 0;

  exec_unit_md_if #(.XLEN(XLEN)) ifc ();
  exec_unit_md #(.XLEN(XLEN), .FWD_EN_B_IMM(FWD_EN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  alu_ctrl_e alu_codes [12] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
                               ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB, ALU_STORE};
  alu_ctrl_e md_codes [8] = '{MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
                              MD_DIV, MD_DIVU, MD_REM, MD_REMU};

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd_m(input logic [1:0] s, input logic [31:0] dflt, input op_t t);
    if (s == 2'b01) return t.wb;
    if (s == 2'b10) return t.mil ? t.mld : t.malu;
    return dflt;
  endfunction

  function automatic logic [31:0] opa_m(input op_t t);
    logic [31:0] base;
    case (t.asel)
      2'd0: base = t.r1;
      2'd1: base = t.pc;
      2'd2: base = t.pc + 32'd4;
      default: base = 32'd0;
    endcase
    return fwd_m(t.fa, base, t);
  endfunction

  function automatic logic [31:0] opb_m(input op_t t);
    return t.bsel ? t.imm : fwd_m(t.fb, t.r2, t);
  endfunction

  function automatic logic [31:0] m_store(input op_t t);
    if (t.ctrl != ALU_STORE) return 32'd0;
    if (t.bsel && !FWD_EN) return t.r2;
    return fwd_m(t.fb, t.r2, t);
  endfunction

  function automatic logic [31:0] m_result(input op_t t);
    logic [31:0] a, b;
    int          sa, sb;
    longint      ps;
    logic [63:0] pu;
    a = opa_m(t); b = opb_m(t);
    sa = a; sb = b;
    case (t.ctrl)
      ALU_ADD, ALU_STORE: return a + b;
      ALU_SUB:   return a - b;
      ALU_SLL:   return a << b[4:0];
      ALU_SLT:   return {31'd0, sa < sb};
      ALU_SLTU:  return {31'd0, a < b};
      ALU_XOR:   return a ^ b;
      ALU_SRL:   return a >> b[4:0];
      ALU_SRA:   return sa >>> b[4:0];
      ALU_OR:    return a | b;
      ALU_AND:   return a & b;
      ALU_PASSB: return b;
`ifdef EXEC_MULDIV_EN
      MD_MUL:    begin pu = {32'd0, a} * {32'd0, b}; return pu[31:0]; end
      MD_MULH:   begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
      MD_MULHSU: begin ps = longint'(sa) * longint'({32'd0, b}); return ps[63:32]; end
      MD_MULHU:  begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REMU:   return (b == 0) ? a : a % b;
`endif
      default:   return 32'd0;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic op_t mk(input logic [5:0] c, input logic [31:0] r1, input logic [31:0] r2);
    op_t t;
    t.ctrl = c; t.asel = 2'd0; t.bsel = 1'b0; t.r1 = r1; t.r2 = r2;
    t.imm = 32'd0; t.pc = 32'd0; t.fa = 2'd0; t.fb = 2'd0;
    t.wb = 32'd0; t.malu = 32'd0; t.mld = 32'd0; t.mil = 1'b0;
    return t;
  endfunction

  function automatic op_t rand_op(input bit md);
    op_t t;
    t.ctrl = md ? md_codes[$urandom_range(7)] : alu_codes[$urandom_range(11)];
    t.asel = 2'($urandom_range(3)); t.bsel = 1'($urandom_range(1));
    t.r1 = $urandom; t.r2 = $urandom; t.imm = $urandom; t.pc = $urandom;
    t.fa = 2'($urandom_range(3)); t.fb = 2'($urandom_range(3));
    t.wb = $urandom; t.malu = $urandom; t.mld = $urandom; t.mil = 1'($urandom_range(1));
    if (md && $urandom_range(3) == 0) begin t.r2 = 32'd0; t.imm = 32'd0; t.wb = 32'd0; end
    if (md && $urandom_range(3) == 0) t.r1 = 32'h8000_0000;
    if (t.ctrl == ALU_STORE && t.bsel) t.fb = 2'd0;
    return t;
  endfunction

  task automatic apply(input op_t t);
    ifc.alu_ctrl = t.ctrl; ifc.op_a_sel = t.asel; ifc.op_b_sel = t.bsel;
    ifc.rdata1 = t.r1; ifc.rdata2 = t.r2; ifc.imm = t.imm; ifc.pc = t.pc;
    ifc.fwd_sel_a = t.fa; ifc.fwd_sel_b = t.fb; ifc.wb_data = t.wb;
    ifc.mem_alu = t.malu; ifc.mem_load_data = t.mld; ifc.mem_is_load = t.mil;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    apply(mk(6'd0, 32'd0, 32'd0));
    #12;
    checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready); end
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
    checks++; if (ifc.out_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", ifc.out_result); end
    checks++; if (ifc.out_store_data !== 32'd0) begin errors++; $display("FAIL reset_store: got %h want 0", ifc.out_store_data); end
    checks++; if (ifc.md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy: got %b want 0", ifc.md_busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic issue_one(input op_t t, input logic [31:0] er, input logic [31:0] es, input string nm);
    apply(t); ifc.out_ready = 1'b1; ifc.in_valid = 1'b1;
    checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b want 1", nm, ifc.in_ready); end
    @(posedge clk); #1; ifc.in_valid = 1'b0;
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_result !== er || ifc.out_store_data !== es) begin
      errors++;
      $display("FAIL %s: got v=%b res=%h st=%h want v=1 res=%h st=%h ctrl=%h",
               nm, ifc.out_valid, ifc.out_result, ifc.out_store_data, er, es, t.ctrl);
    end
    @(posedge clk); #1;
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain: got out_valid %b want 0", nm, ifc.out_valid); end
  endtask

  task automatic test_directed;
    op_t t;
    issue_one(mk(ALU_ADD, 32'd5, 32'd7), 32'd12, 32'd0, "add_5_7");
    t = mk(ALU_ADD, 32'd0, 32'd0);
    t.fa = 2'b10; t.mil = 1'b1; t.mld = 32'h100; t.malu = 32'hDEAD_0000; t.imm = 32'd4; t.bsel = 1'b1;
    issue_one(t, 32'h104, 32'd0, "fwd_mem_load");
    t = mk(ALU_STORE, 32'h1000, 32'hAAAA_5555);
    t.fb = 2'b01; t.wb = 32'h1234_5678;
    issue_one(t, 32'h1000 + 32'h1234_5678, 32'h1234_5678, "store_fwd_wb");
  endtask

  task automatic test_random_alu;
    op_t t;
    for (int i = 0; i < 40; i++) begin
      t = rand_op(1'b0);
      issue_one(t, m_result(t), m_store(t), "alu_rand");
    end
  endtask

  task automatic test_unknown;
    logic [5:0] codes [3] = '{6'h0C, 6'h1F, 6'h3F};
    for (int i = 0; i < 3; i++) issue_one(mk(codes[i], $urandom, $urandom), 32'd0, 32'd0, "unknown_op");
  endtask

  task automatic test_back_to_back;
    op_t q [$];
    op_t t;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) q.push_back(rand_op(1'b0));
    for (int i = 0; i < 20; i++) begin
      apply(q[i]); ifc.in_valid = 1'b1;
      checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1 at %0d", ifc.in_ready, i); end
      @(posedge clk); #1;
      t = q[i];
      checks++;
      if (ifc.out_valid !== 1'b1 || ifc.out_result !== m_result(t) || ifc.out_store_data !== m_store(t)) begin
        errors++;
        $display("FAIL b2b: got v=%b res=%h st=%h want v=1 res=%h st=%h",
                 ifc.out_valid, ifc.out_result, ifc.out_store_data, m_result(t), m_store(t));
      end
    end
    ifc.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    op_t t1, t2;
    t1 = rand_op(1'b0); t2 = rand_op(1'b0);
    apply(t1); ifc.out_ready = 1'b0; ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    apply(t2);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ifc.out_valid !== 1'b1 || ifc.out_result !== m_result(t1) || ifc.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: got v=%b res=%h rdy=%b want v=1 res=%h rdy=0",
                 ifc.out_valid, ifc.out_result, ifc.in_ready, m_result(t1));
      end
      @(posedge clk); #1;
    end
    ifc.out_ready = 1'b1; #1;
    checks++; if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", ifc.in_ready); end
    @(posedge clk); #1; ifc.in_valid = 1'b0;
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_result !== m_result(t2) || ifc.out_store_data !== m_store(t2)) begin
      errors++;
      $display("FAIL bp_next: got v=%b res=%h st=%h want v=1 res=%h st=%h",
               ifc.out_valid, ifc.out_result, ifc.out_store_data, m_result(t2), m_store(t2));
    end
    @(posedge clk); #1;
  endtask

`ifdef EXEC_MULDIV_EN
  task automatic run_md(input op_t t, input logic [31:0] exp, input string nm);
    int cyc;
    bit busy_ok;
    apply(t); ifc.out_ready = 1'b1; ifc.in_valid = 1'b1;
    @(posedge clk); #1; ifc.in_valid = 1'b0;
    cyc = 1; busy_ok = 1'b1;
    while (ifc.out_valid !== 1'b1 && cyc < 100) begin
      if (ifc.in_ready !== 1'b0 || ifc.md_busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1; cyc++;
    end
    checks++; if (cyc != 34) begin errors++; $display("FAIL %s_latency: got %0d cycles want 34", nm, cyc); end
    checks++; if (!busy_ok) begin errors++; $display("FAIL %s_busy: in_ready/md_busy wrong while running, want 0/1", nm); end
    checks++; if (ifc.out_result !== exp) begin errors++; $display("FAIL %s: got %h want %h", nm, ifc.out_result, exp); end
    checks++; if (ifc.out_store_data !== 32'd0) begin errors++; $display("FAIL %s_store: got %h want 0", nm, ifc.out_store_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_muldiv;
    op_t t;
    run_md(mk(MD_MULH, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF, "mulh_m1x2");
    run_md(mk(MD_MUL,  32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFE, "mul_m1x2");
    run_md(mk(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000, "div_ovf");
    run_md(mk(MD_REM,  32'h8000_0000, 32'hFFFF_FFFF), 32'd0, "rem_ovf");
    run_md(mk(MD_DIVU, 32'd9, 32'd0), 32'hFFFF_FFFF, "divu_by0");
    run_md(mk(MD_REMU, 32'd9, 32'd0), 32'd9, "remu_by0");
    for (int i = 0; i < 16; i++) begin
      t = rand_op(1'b1);
      run_md(t, m_result(t), "md_rand");
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    apply(mk(MD_MUL, 32'h1234_5678, 32'h9ABC_DEF1)); ifc.out_ready = 1'b1; ifc.in_valid = 1'b1;
    @(posedge clk); #1; ifc.in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0; #1;
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.out_result !== 32'd0 || ifc.out_store_data !== 32'd0 ||
        ifc.md_busy !== 1'b0 || ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got v=%b res=%h st=%h busy=%b rdy=%b want 0 0 0 0 1",
               ifc.out_valid, ifc.out_result, ifc.out_store_data, ifc.md_busy, ifc.in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ifc.out_valid !== 1'b0) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL reset_mid_no_result: got out_valid 1 want 0"); end
  endtask
`else
  task automatic test_md_disabled;
    for (int i = 0; i < 8; i++) begin
      issue_one(mk(md_codes[i], $urandom, 32'd3), 32'd0, 32'd0, "md_off");
      checks++; if (ifc.md_busy !== 1'b0) begin errors++; $display("FAIL md_off_busy: got %b want 0", ifc.md_busy); end
    end
  endtask

  task automatic test_reset_mid;
    apply(mk(ALU_ADD, 32'h0F00, 32'h00F0)); ifc.out_ready = 1'b0; ifc.in_valid = 1'b1;
    @(posedge clk); #1; ifc.in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0; #1;
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.out_result !== 32'd0 || ifc.out_store_data !== 32'd0 ||
        ifc.md_busy !== 1'b0 || ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got v=%b res=%h st=%h busy=%b rdy=%b want 0 0 0 0 1",
               ifc.out_valid, ifc.out_result, ifc.out_store_data, ifc.md_busy, ifc.in_ready);
    end
    @(negedge clk); rst_n = 1'b1; ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_no_result: got out_valid 1 want 0"); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random_alu();
    test_unknown();
    test_back_to_back();
    test_backpressure();
`ifdef EXEC_MULDIV_EN
    test_muldiv();
`else
    test_md_disabled();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/exec_unit_md.md
EXEC_UNIT_MD -- requirements
Module: exec_unit_md

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width in bits (>= 8, even).
REQ-002 The block SHALL have parameter FWD_EN_B_IMM, default 0; 1 lets forwarding override op_b_sel=1 (imm) for store data only.
REQ-003 The block SHALL have port clk  in  1  single clock, rising edge.
REQ-004 The block SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports in_valid in 1 and in_ready out 1: decode-to-execute handshake.
REQ-006 The block SHALL have ports op_a_sel in 2, op_b_sel in 1, alu_ctrl in 6: operand select, ALU/MD opcode.
REQ-007 The block SHALL have ports rdata1, rdata2, imm, pc, each in XLEN: decode operands.
REQ-008 The block SHALL have ports fwd_sel_a, fwd_sel_b in 2: 00 none, 01 WB, 10 MEM, 11 none.
REQ-009 The block SHALL have ports wb_data, mem_alu, mem_load_data in XLEN and mem_is_load in 1: forward sources.
REQ-010 The block SHALL have ports out_valid out 1 and out_ready in 1: execute-to-memory handshake.
REQ-011 The block SHALL have ports out_result and out_store_data out XLEN, and md_busy out 1.

Function
REQ-012 Operand A SHALL be: fwd 01 -> wb_data; 10 -> mem_load_data if mem_is_load else mem_alu; else op_a_sel 00 rdata1, 01 pc, 10 pc+4, 11 zero.
REQ-013 Operand B SHALL be imm when op_b_sel=1, otherwise forwarded per fwd_sel_b as REQ-012, else rdata2.
REQ-014 out_store_data SHALL be forwarded rdata2 (REQ-013 rule, ignoring op_b_sel) when alu_ctrl=STORE, else zero.
REQ-015 A transfer SHALL occur on a rising edge with in_valid && in_ready; operands are sampled only on that edge.
REQ-016 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready), combinationally.
REQ-017 Non-MD ops SHALL register out_result/out_store_data and raise out_valid one cycle after transfer (latency 1).
REQ-018 FSM states SHALL be IDLE, MD_RUN, MD_DONE; IDLE->MD_RUN on transfer of an MD op; MD_RUN->MD_DONE when the iteration counter reaches XLEN-1; MD_DONE->IDLE on the cycle after MD_DONE, loading the output register.
REQ-019 MD latency SHALL be exactly XLEN+2 cycles from transfer to out_valid; md_busy=1 in MD_RUN and MD_DONE.
REQ-020 MUL/MULH/MULHSU/MULHU SHALL produce the low/high XLEN bits of the 2*XLEN product with RV32M signedness.
REQ-021 DIV/DIVU/REM/REMU SHALL use restoring division; divide by zero gives quotient all-ones, remainder = dividend.
REQ-022 Signed overflow (most-negative / -1) SHALL give quotient = most-negative, remainder = 0.
REQ-023 While out_valid && !out_ready, out_result, out_store_data and out_valid SHALL hold unchanged.
REQ-024 out_valid SHALL clear on out_ready when no new result is loaded that edge; simultaneous drain and load keeps it 1.
REQ-025 Unknown alu_ctrl codes SHALL produce out_result = 0 with normal latency 1.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, counter 0, out_valid 0, out_result 0, out_store_data 0, md_busy 0.
REQ-027 Reset during MD_RUN SHALL abort the operation with no result emitted after release.
REQ-028 in_ready SHALL be 1 during reset.

Configuration
REQ-029 Macro EXEC_MULDIV_EN SHALL compile in the MD path, FSM states MD_RUN/MD_DONE and counter.
REQ-030 Without EXEC_MULDIV_EN, MD opcodes SHALL follow REQ-025, md_busy SHALL tie 0, FSM stays IDLE.

Structure
REQ-031 A shared package SHALL hold the alu_ctrl codes (incl. STORE and eight MD codes), opcode constants, fwd_sel encodings and the FSM state enum.
REQ-032 The iterative multiply/divide engine SHALL be sub-module muldiv_iter (start/done, XLEN parameter); the combinational ALU is reused unchanged.

Verification
REQ-033 ADD rdata1=5, rdata2=7, fwd 00 -> out_valid next cycle, out_result=12.
REQ-034 fwd_sel_a=10, mem_is_load=1, mem_load_data=0x100, imm=4, op_b_sel=1, ADD -> out_result=0x104.
REQ-035 MUL 0xFFFFFFFF*2 (MULH and MUL) -> 0xFFFFFFFF / 0xFFFFFFFE after exactly 34 cycles, in_ready 0 meanwhile.
REQ-036 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
REQ-037 out_ready held 0 for 3 cycles after a result -> out_result stable, in_ready 0; release -> next op accepted.
REQ-038 rst_n pulsed low at MD cycle 10 -> all outputs 0 immediately, no out_valid after release.
